// File: rtl/iob_cache_be_mem.sv
// Back-end memory responder for the cache: IOb native slave serving word reads and
// byte-strobed writes from an external single-port sync RAM, with a programmable ack delay.
module iob_cache_be_mem #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int ACK_DELAY  = 2,
  parameter int CNT_W      = 16,
  localparam int NBYTES    = DATA_W / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  iob_avalid_i,
  input  logic [ADDR_W-1:0]     iob_addr_i,
  input  logic [DATA_W-1:0]     iob_wdata_i,
  input  logic [NBYTES-1:0]     iob_wstrb_i,
  output logic                  iob_ready_o,
  output logic                  iob_rvalid_o,
  output logic [DATA_W-1:0]     iob_rdata_o,
  output logic                  mem_en_o,
  output logic [NBYTES-1:0]     mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic [CNT_W-1:0]      rd_cnt_o,
  output logic [CNT_W-1:0]      wr_cnt_o,
  output logic                  err_o
);

  localparam int OFF_W = $clog2(NBYTES);
  localparam logic [7:0] CNT_INIT = (ACK_DELAY > 0) ? 8'(ACK_DELAY - 1) : 8'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACC,
    S_RD,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                oor_q, oor_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   widx;
  logic                in_range;
  logic                is_wr;

  // Word index keeps full width so the range test sees every upper bit.
  assign widx     = iob_addr_i >> OFF_W;
  assign in_range = (widx >> MEM_ADDR_W) == '0;
  assign is_wr    = |iob_wstrb_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    oor_d       = oor_q;
    rdata_d     = rdata_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    err_d       = err_q;
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    case (state_q)
      S_IDLE: begin
        if (iob_avalid_i) begin
          state_d = (ACK_DELAY == 0) ? S_ACC : S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (!iob_avalid_i)       state_d = S_IDLE;
        else if (cnt_q == 8'd0)  state_d = S_ACC;
        else                     cnt_d   = cnt_q - 8'd1;
      end
      S_ACC: begin
        mem_en_o   = in_range;
        mem_addr_o = widx[MEM_ADDR_W-1:0];
        oor_d      = !in_range;
        if (!in_range) err_d = 1'b1;
        if (is_wr) begin
          // Out-of-range writes are acknowledged but never reach the RAM.
          mem_we_o    = in_range ? iob_wstrb_i : '0;
          mem_wdata_o = iob_wdata_i;
          if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
          state_d = S_IDLE;
        end else begin
          if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
          state_d = S_RD;
        end
      end
      S_RD: begin
        rdata_d = oor_q ? '0 : mem_rdata_i;
        state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      oor_q    <= 1'b0;
      rdata_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      oor_q    <= oor_d;
      rdata_q  <= rdata_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
    end
  end

  assign iob_ready_o  = (state_q == S_ACC);
  assign iob_rvalid_o = (state_q == S_RESP);
  assign iob_rdata_o  = rdata_q;
  assign rd_cnt_o     = rd_cnt_q;
  assign wr_cnt_o     = wr_cnt_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_iob_cache_be_mem.sv
// Bench for iob_cache_be_mem: directed requests, read data checked by a scoreboard monitor.
module tb_iob_cache_be_mem;
  localparam int AW = 24, DW = 32, MAW = 10, NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          avalid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [NB-1:0] wstrb;
  logic          ready, rvalid, mem_en, err;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [NB-1:0] mem_we;
  logic [MAW-1:0] mem_addr;
  logic [15:0]   rd_cnt, wr_cnt;

  iob_cache_be_mem #(.ADDR_W(AW), .DATA_W(DW), .MEM_ADDR_W(MAW), .ACK_DELAY(2), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .iob_avalid_i(avalid), .iob_addr_i(addr), .iob_wdata_i(wdata),
    .iob_wstrb_i(wstrb), .iob_ready_o(ready), .iob_rvalid_o(rvalid), .iob_rdata_o(rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .err_o(err));

  // second instance: no ack delay, 2-bit counters
  logic          s_avalid, s_ready, s_rvalid, s_mem_en, s_err;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata, s_mem_wdata, s_mem_rdata;
  logic [NB-1:0] s_wstrb, s_mem_we;
  logic [3:0]    s_mem_addr;
  logic [1:0]    s_rd_cnt, s_wr_cnt;
  assign s_mem_rdata = '0;

  iob_cache_be_mem #(.ADDR_W(AW), .DATA_W(DW), .MEM_ADDR_W(4), .ACK_DELAY(0), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .iob_avalid_i(s_avalid), .iob_addr_i(s_addr), .iob_wdata_i(s_wdata),
    .iob_wstrb_i(s_wstrb), .iob_ready_o(s_ready), .iob_rvalid_o(s_rvalid), .iob_rdata_o(s_rdata),
    .mem_en_o(s_mem_en), .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata),
    .mem_rdata_i(s_mem_rdata), .rd_cnt_o(s_rd_cnt), .wr_cnt_o(s_wr_cnt), .err_o(s_err));

  // sync RAM model with byte enables, read-first
  logic [DW-1:0] ram [0:(1<<MAW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < NB; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_ready = 0;
  logic [DW-1:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (ready) last_ready = cyc;
    if (rvalid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rvalid: rdata %0h with nothing expected", rdata);
      end else begin
        e = exp_q.pop_front();
        check("rdata", rdata, e);
        check("rvalid_lat", cyc - last_ready, 2);
        check("rdy_rvalid_excl", ready, 0);
      end
    end
  end

  task automatic req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s,
                     input logic [DW-1:0] exp_rd, input logic exp_en, input bit sync, input bit hold);
    int n;
    bit got;
    if (sync) begin @(posedge clk); #1; end
    avalid = 1'b1; addr = a; wdata = d; wstrb = s;
    if (s == '0) exp_q.push_back(exp_rd);
    n = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1; else n++;
    end
    if (!got) begin
      fail_now("ready_timeout");
      avalid = 1'b0;
      if (s == '0) void'(exp_q.pop_back());
      return;
    end
    check("ready_lat", n, 3);
    check("mem_en", mem_en, exp_en);
    check("mem_we", mem_we, (exp_en && s != '0) ? s : '0);
    if (!hold) avalid = 1'b0;
    if (s == '0) begin
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (rvalid) got = 1;
      end
      if (!got) fail_now("rvalid_timeout");
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int bad;
    int n;
    bit got;
    avalid = 0; addr = '0; wdata = '0; wstrb = '0;
    s_avalid = 0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {ready, rvalid, mem_en, mem_we, err}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_cnt", {rd_cnt, wr_cnt}, 0);
    check("rst_mem", {mem_addr, mem_wdata}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // basic write then read
    req(24'h40, 32'hDEADBEEF, 4'hF, '0, 1'b1, 1, 0);
    req(24'h40, '0, 4'h0, 32'hDEADBEEF, 1'b1, 1, 0);
    @(negedge clk);
    check("wr_cnt_1", wr_cnt, 1);
    check("rd_cnt_1", rd_cnt, 1);

    // partial strobe
    req(24'h40, 32'h00005500, 4'h2, '0, 1'b1, 1, 0);
    req(24'h40, '0, 4'h0, 32'hDEAD55EF, 1'b1, 1, 0);

    // out of range; widx 1024 must not alias word 0
    req(24'h0, 32'h11111111, 4'hF, '0, 1'b1, 1, 0);
    req(24'h1000, 32'hCAFEF00D, 4'hF, '0, 1'b0, 1, 0);
    @(negedge clk);
    check("err_set", err, 1);
    req(24'h1000, '0, 4'h0, 32'h0, 1'b0, 1, 0);
    req(24'h0, '0, 4'h0, 32'h11111111, 1'b1, 1, 0);
    @(negedge clk);
    check("err_sticky", err, 1);
    check("cnt_after_oor", {rd_cnt, wr_cnt}, {16'd4, 16'd4});
    pulse_reset();
    @(negedge clk);
    check("err_cleared", err, 0);

    // line fill with avalid held across reads
    req(24'h0, 32'h10203040, 4'hF, '0, 1'b1, 1, 0);
    req(24'h4, 32'h50607080, 4'hF, '0, 1'b1, 1, 0);
    req(24'h8, 32'h90A0B0C0, 4'hF, '0, 1'b1, 1, 0);
    req(24'hC, 32'hD0E0F001, 4'hF, '0, 1'b1, 1, 0);
    pulse_reset();
    req(24'h0, '0, 4'h0, 32'h10203040, 1'b1, 1, 1);
    req(24'h4, '0, 4'h0, 32'h50607080, 1'b1, 0, 1);
    req(24'h8, '0, 4'h0, 32'h90A0B0C0, 1'b1, 0, 1);
    req(24'hC, '0, 4'h0, 32'hD0E0F001, 1'b1, 0, 0);
    @(negedge clk);
    check("fill_cnt", {rd_cnt, wr_cnt}, {16'd4, 16'd0});

    // abort during WAIT
    @(posedge clk); #1;
    avalid = 1; addr = 24'h40; wdata = 32'h12345678; wstrb = 4'hF;
    @(negedge clk);
    @(negedge clk);
    avalid = 0;
    bad = 0;
    repeat (8) begin
      if (ready || mem_en) bad++;
      @(negedge clk);
    end
    check("abort_quiet", bad, 0);
    req(24'h40, '0, 4'h0, 32'hDEAD55EF, 1'b1, 1, 0);

    // reset while in RD
    @(posedge clk); #1;
    avalid = 1; addr = 24'h4; wstrb = 4'h0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1;
    end
    if (!got) fail_now("rd_abort_ready");
    avalid = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rdrst_ctl", {ready, rvalid, mem_en, mem_we, err}, 0);
    check("rdrst_rdata", rdata, 0);
    check("rdrst_cnt", {rd_cnt, wr_cnt}, 0);
    check("rdrst_mem", {mem_addr, mem_wdata}, 0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid || ready || mem_en) bad++;
    end
    check("rdrst_quiet", bad, 0);

    // counter saturation, zero ack delay
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      s_avalid = 1; s_addr = AW'(i * 4); s_wdata = 32'hA5A50000 | i; s_wstrb = 4'hF;
      n = 0; got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (s_ready) got = 1; else n++;
      end
      if (!got) fail_now("s_ready_timeout");
      check("s_lat", n, 1);
      check("s_mem", {s_mem_en, s_mem_we, s_mem_addr}, {1'b1, 4'hF, 4'(i)});
      check("s_wdata", s_mem_wdata, 32'hA5A50000 | i);
      s_avalid = 0;
      @(negedge clk);
      check("s_wr_cnt", s_wr_cnt, (i < 3) ? i + 1 : 3);
    end
    check("s_misc", {s_rvalid, s_err, s_rd_cnt, s_rdata}, 0);

    repeat (5) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
